ccu_serial_ctrl: RTL and testbench



---
 rtl/ccu_serial_ctrl.sv | 69 ++++++
 tb/tb_ccu_serial_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ccu_serial_ctrl.sv
// ccu_serial_ctrl: WIDTH-bit adder sequenced through one 2-bit slice, LSB pair first
module ccu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [7:0]       step
);
  localparam int STEPS = WIDTH / 2;
  localparam logic [7:0] LAST = 8'(STEPS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DN} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic carry;
  logic [2:0] s;
  always_comb s = {1'b0, a_sh[1:0]} + {1'b0, b_sh[1:0]} + {2'b0, carry};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      cout <= 1'b0;
      step <= '0;
      carry <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh <= op_a;
          b_sh <= op_b;
          carry <= cin;
          result <= '0;
          cout <= 1'b0;
          step <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          result[2*int'(step) +: 2] <= s[1:0];
          carry <= s[2];
          a_sh <= a_sh >> 2;
          b_sh <= b_sh >> 2;
          if (step == LAST) begin
            cout <= s[2];
            step <= '0;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DN;
          end else step <= step + 8'd1;
        end
        DN: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ccu_serial_ctrl.sv
// tb_ccu_serial_ctrl: vector table, corner sequences and random adds against an arithmetic model
module tb_ccu_serial_ctrl;
  localparam int WIDTH = 8;
  localparam int STEPS = WIDTH / 2;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cin = 1'b0;
  logic [WIDTH-1:0] op_a = '0, op_b = '0;
  logic busy, done, cout;
  logic [WIDTH-1:0] result;
  logic [7:0] step;
  int passed = 0, total = 0;
  typedef struct {
    logic [WIDTH-1:0] a, b;
    logic c;
    logic [WIDTH-1:0] r;
    logic co;
  } vec_t;
  vec_t vt[6];

  ccu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .step(step)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    op_a = a;
    op_b = b;
    cin = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a = WIDTH'($urandom);
    op_b = WIDTH'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic finish(input logic [WIDTH-1:0] er, input logic ec);
    for (int k = 0; k < STEPS; k++) begin
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_step", step, k);
      tick();
    end
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_result", result, er);
    check("done_cout", cout, ec);
    tick();
    check("post_done", done, 0);
    check("post_result", result, er);
  endtask

  initial begin
    vt[0] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vt[3] = '{8'h03, 8'h04, 1'b1, 8'h08, 1'b0};
    vt[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vt[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    // reset with start held; first edge after release must accept
    op_a = 8'h01;
    op_b = 8'h02;
    start = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_cout", cout, 0);
      check("rst_step", step, 0);
    end
    reset = 1'b0;
    tick();
    start = 1'b0;
    finish(8'h03, 1'b0);
    for (int i = 0; i < 6; i++) begin
      launch(vt[i].a, vt[i].b, vt[i].c);
      finish(vt[i].r, vt[i].co);
    end
    // start and operand changes during RUN are ignored
    launch(8'h12, 8'h34, 1'b0);
    start = 1'b1;
    op_a = 8'hFF;
    op_b = 8'hFF;
    for (int k = 0; k < STEPS; k++) begin
      check("ign_step", step, k);
      tick();
    end
    check("ign_done", done, 1);
    check("ign_result", result, 8'h46);
    start = 1'b0;
    begin
      int extra = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done || busy) extra++;
      end
      check("ign_no_second", extra, 0);
    end
    // reset mid-RUN abandons the add
    launch(8'h80, 8'h80, 1'b0);
    tick();
    tick();
    check("abort_step", step, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_cout", cout, 0);
    begin
      int extra = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (done) extra++;
      end
      check("abort_no_done", extra, 0);
    end
    launch(8'h03, 8'h04, 1'b1);
    finish(8'h08, 1'b0);
    // start held: one add every STEPS+2 cycles
    op_a = 8'h7F;
    op_b = 8'h01;
    cin = 1'b0;
    start = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) begin
      int seen = -1;
      for (int k = 0; k < STEPS + 2; k++) begin
        if (done && seen < 0) begin
          seen = k;
          check("bb_result", result, 8'h80);
          check("bb_cout", cout, 0);
        end
        tick();
      end
      check("bb_done_at", seen, STEPS);
      check("bb_restart", busy, 1);
    end
    start = 1'b0;
    for (int i = 0; i < STEPS + 2; i++) tick();
    // random adds against plain arithmetic
    for (int i = 0; i < 25; i++) begin
      logic [WIDTH-1:0] a, b;
      logic c;
      logic [WIDTH:0] sum;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      c = 1'($urandom);
      sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
      launch(a, b, c);
      finish(sum[WIDTH-1:0], sum[WIDTH]);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  always @(negedge clk) if (busy && done) begin
    total++;
    $display("FAIL busy_done_overlap: busy=1 done=1 required not both");
  end
endmodule
